// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: drives trial codes to a comparator and
// resolves a WIDTH-bit result. Optional macro SAR_ADC_CTRL_CONTINUOUS_EN restarts on each handshake.
module sar_adc_ctrl #(
  parameter int WIDTH         = 10,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cmp_in,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [1:0]       fsm_state
);

  // Result port handshake: result_valid rises with a stable result and stays
  // high, with result unchanged, until an edge where result_valid & result_ready;
  // that edge is the single transfer.

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [IW-1:0]    TOP_IDX  = IW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB_CODE = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DECIDE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // With no settle time every trial goes straight to its decision edge.
  localparam state_t TRIAL_ST = (SETTLE_CYCLES == 0) ? DECIDE : SETTLE;

  state_t           state, state_nx;
  logic [WIDTH-1:0] work, work_nx;
  logic [WIDTH-1:0] dac_nx, result_nx;
  logic [IW-1:0]    bit_idx, idx_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             valid_nx, busy_nx;
  logic             load;
  logic [WIDTH-1:0] decided, trial;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      work         <= '0;
      dac_code     <= '0;
      bit_idx      <= TOP_IDX;
      cnt          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nx;
      work         <= work_nx;
      dac_code     <= dac_nx;
      bit_idx      <= idx_nx;
      cnt          <= cnt_nx;
      result       <= result_nx;
      result_valid <= valid_nx;
      busy         <= busy_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    work_nx   = work;
    dac_nx    = dac_code;
    idx_nx    = bit_idx;
    cnt_nx    = cnt;
    result_nx = result;
    valid_nx  = result_valid;
    busy_nx   = busy;
    load      = 1'b0;
    decided   = work;
    trial     = work;

    case (state)
      IDLE: begin
        load = start;
      end
      SETTLE: begin
        if (cnt == CNT_LAST) begin
          state_nx = DECIDE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      DECIDE: begin
        // Only this edge looks at the comparator: keep or clear the trial bit.
        decided          = work;
        decided[bit_idx] = cmp_in;
        work_nx          = decided;
        if (bit_idx != '0) begin
          trial                   = decided;
          trial[bit_idx - IW'(1)] = 1'b1;
          dac_nx                  = trial;
          idx_nx                  = bit_idx - IW'(1);
          cnt_nx                  = '0;
          state_nx                = TRIAL_ST;
        end else begin
          result_nx = decided;
          dac_nx    = decided;
          valid_nx  = 1'b1;
          busy_nx   = 1'b0;
          state_nx  = DONE;
        end
      end
      DONE: begin
        if (result_ready) begin
          valid_nx = 1'b0;
`ifdef SAR_ADC_CTRL_CONTINUOUS_EN
          load     = 1'b1;
`else
          state_nx = IDLE;
`endif
        end
      end
      default: state_nx = IDLE;
    endcase

    if (load) begin
      state_nx = TRIAL_ST;
      dac_nx   = MSB_CODE;
      work_nx  = '0;
      idx_nx   = TOP_IDX;
      cnt_nx   = '0;
      busy_nx  = 1'b1;
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl: default instance plus a zero-settle instance,
// each closed through an ideal comparator (vin >= dac_code).
module tb_sar_adc_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start_a, cmp_a, ready_a, busy_a, valid_a;
  logic [9:0] vin_a, dac_a, res_a;
  logic [1:0] st_a;
  logic       start_b, cmp_b, ready_b, busy_b, valid_b;
  logic [9:0] vin_b, dac_b, res_b;
  logic [1:0] st_b;

  assign cmp_a = (vin_a >= dac_a);
  assign cmp_b = (vin_b >= dac_b);

  sar_adc_ctrl #(.WIDTH(10), .SETTLE_CYCLES(2)) u_dut (
    .clk(clk), .reset(reset), .start(start_a), .cmp_in(cmp_a),
    .dac_code(dac_a), .busy(busy_a), .result(res_a),
    .result_valid(valid_a), .result_ready(ready_a), .fsm_state(st_a)
  );

  sar_adc_ctrl #(.WIDTH(10), .SETTLE_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start_b), .cmp_in(cmp_b),
    .dac_code(dac_b), .busy(busy_b), .result(res_b),
    .result_valid(valid_b), .result_ready(ready_b), .fsm_state(st_b)
  );

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DECIDE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;
`ifdef SAR_ADC_CTRL_CONTINUOUS_EN
  localparam logic [1:0] POST_ST   = 2'd1;
  localparam logic       POST_BUSY = 1'b1;
  localparam int         N_RESULTS = 3;
`else
  localparam logic [1:0] POST_ST   = 2'd0;
  localparam logic       POST_BUSY = 1'b0;
  localparam int         N_RESULTS = 1;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  int xfers        = 0;

  logic [9:0] trace [64];
  logic [1:0] st_trace [64];

  always @(posedge clk) if (valid_a && ready_a) xfers <= xfers + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Latency counts edges from the one that samples start (lat=1 right after it)
  // up to the first sample showing result_valid; 200 means it never came.
  task automatic run_conv_a(input logic [9:0] v, output int lat);
    vin_a = v;
    @(negedge clk);
    start_a = 1'b1;
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      start_a = 1'b0;
      lat++;
      if (lat < 64) trace[lat] = dac_a;
      if (valid_a) break;
    end
  endtask

  task automatic run_conv_b(input logic [9:0] v, output int lat);
    vin_b = v;
    @(negedge clk);
    start_b = 1'b1;
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      start_b = 1'b0;
      lat++;
      if (lat < 64) st_trace[lat] = st_b;
      if (valid_b) break;
    end
  endtask

  initial begin
    int lat, x0, n, bad, not_decide;
    int tv [4];
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
    ready_a = 1'b1; ready_b = 1'b1;
    vin_a = '0; vin_b = '0;
    repeat (3) @(negedge clk);

    check("rst_dac",   32'(dac_a),   32'h0);
    check("rst_res",   32'(res_a),   32'h0);
    check("rst_valid", 32'(valid_a), 32'h0);
    check("rst_busy",  32'(busy_a),  32'h0);
    check("rst_state", 32'(st_a),    32'(ST_IDLE));
    reset = 1'b0;

    // 0x2A5 with trial sequence
    do_reset();
    ready_a = 1'b1;
    run_conv_a(10'h2A5, lat);
    check("2a5_lat",   32'(lat),     32'd31);
    check("2a5_res",   32'(res_a),   32'h2A5);
    check("2a5_state", 32'(st_a),    32'(ST_DONE));
    check("2a5_busy",  32'(busy_a),  32'h0);
    check("2a5_dac",   32'(dac_a),   32'h2A5);
    check("trial0",    32'(trace[1]),  32'h200);
    check("trial1",    32'(trace[4]),  32'h300);
    check("trial2",    32'(trace[7]),  32'h280);
    check("trial3",    32'(trace[10]), 32'h2C0);
    check("trial4",    32'(trace[13]), 32'h2A0);
    check("busy_conv", 32'(busy_a),    32'h0);
    @(negedge clk);
    check("2a5_post_valid", 32'(valid_a), 32'h0);
    check("2a5_post_state", 32'(st_a),    32'(POST_ST));
    check("2a5_post_res",   32'(res_a),   32'h2A5);

    // extremes
    do_reset();
    run_conv_a(10'h000, lat);
    check("zero_lat",  32'(lat),    32'd31);
    check("zero_res",  32'(res_a),  32'h000);
    check("zero_busy", 32'(busy_a), 32'h0);
    @(negedge clk);
    check("zero_post_busy", 32'(busy_a), 32'(POST_BUSY));
    do_reset();
    run_conv_a(10'h3FF, lat);
    check("full_lat",  32'(lat),    32'd31);
    check("full_res",  32'(res_a),  32'h3FF);
    check("full_busy", 32'(busy_a), 32'h0);
    @(negedge clk);
    check("full_post_busy", 32'(busy_a), 32'(POST_BUSY));

    // backpressure, start pulses in DONE are dropped
    do_reset();
    ready_a = 1'b0;
    run_conv_a(10'h155, lat);
    check("bp_lat", 32'(lat),   32'd31);
    check("bp_res", 32'(res_a), 32'h155);
    x0 = xfers;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start_a = (k == 2);
      check("bp_hold_res",   32'(res_a),   32'h155);
      check("bp_hold_valid", 32'(valid_a), 32'h1);
      check("bp_hold_dac",   32'(dac_a),   32'h155);
      check("bp_hold_state", 32'(st_a),    32'(ST_DONE));
    end
    ready_a = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("bp_xfer_valid", 32'(valid_a),    32'h0);
    check("bp_xfer_state", 32'(st_a),       32'(POST_ST));
    check("bp_xfer_res",   32'(res_a),      32'h155);
    check("bp_xfer_count", 32'(xfers - x0), 32'd1);
    repeat (5) @(negedge clk);
    check("bp_one_xfer",  32'(xfers - x0), 32'd1);
    check("bp_after_busy", 32'(busy_a),    32'(POST_BUSY));

    // reset mid-conversion
    do_reset();
    vin_a = 10'h3A0;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_dac",   32'(dac_a),   32'h0);
    check("abort_res",   32'(res_a),   32'h0);
    check("abort_valid", 32'(valid_a), 32'h0);
    check("abort_busy",  32'(busy_a),  32'h0);
    check("abort_state", 32'(st_a),    32'(ST_IDLE));
    reset = 1'b0;
    run_conv_a(10'h0F0, lat);
    check("abort_next_lat", 32'(lat),   32'd31);
    check("abort_next_res", 32'(res_a), 32'h0F0);

    // zero settle time
    do_reset();
    run_conv_b(10'h001, lat);
    check("s0_lat",  32'(lat),   32'd11);
    check("s0_res",  32'(res_b), 32'h001);
    not_decide = 0;
    for (int i = 1; i <= 10; i++) if (st_trace[i] != ST_DECIDE) not_decide++;
    check("s0_all_decide", 32'(not_decide), 32'd0);

    // continuous mode: one start
    do_reset();
    ready_a = 1'b1;
    vin_a   = 10'h200;
    n = 0; bad = 0;
    for (int i = 0; i < 4; i++) tv[i] = 0;
    @(negedge clk);
    start_a = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (valid_a) begin
        if (n < 4) tv[n] = c;
        n++;
        if (res_a != 10'h200) bad++;
      end
    end
    check("cont_count", 32'(n),     32'(N_RESULTS));
    check("cont_value", 32'(bad),   32'd0);
    check("cont_first", 32'(tv[0]), 32'd31);
`ifdef SAR_ADC_CTRL_CONTINUOUS_EN
    check("cont_gap1", 32'(tv[1] - tv[0]), 32'd31);
    check("cont_gap2", 32'(tv[2] - tv[1]), 32'd31);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
